traffic_light_checker: RTL
==========================

TRAFFIC_LIGHT_CHECKER -- requirements
Module: traffic_light_checker

Interface
REQ-001 Parameter YEL_CYC, default 1: required dwell in cycles of phases YR and RY.
REQ-002 Parameter ALLRED_CYC, default 1: required dwell in cycles of phase RR.
REQ-003 Parameter CNT_W, default 8: width of the violation counter.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 hwy  input  2  highway light code: RED=00, YELLOW=01, GREEN=10, 11 illegal.
REQ-007 cntry  input  2  country-road light code, same encoding as hwy.
REQ-008 sensor  input  1  country-road vehicle sensor, the same signal that drives the controller.
REQ-009 phase  output  3  decoded phase of the previous sample: GR=0, YR=1, RR=2, RG=3, RY=4, ILL=7.
REQ-010 err  output  1  sticky error flag.
REQ-011 err_code  output  3  code of the first error since reset; 0 means none.
REQ-012 viol_cnt  output  CNT_W  saturating count of cycles containing at least one violation.
REQ-013 cycle_done  output  1  one-cycle pulse marking a completed RY->GR transition.

Function
REQ-014 Each cycle the block shall sample {hwy, cntry, sensor} and register the results; every output shall reflect the sample from exactly one cycle earlier.
REQ-015 Decode: GR=(10,00), YR=(01,00), RR=(00,00), RG=(00,10), RY=(00,01); any other pair decodes to ILL.
REQ-016 Error codes, highest priority first: 1 = illegal code (either input equal to 11); 2 = conflict (both roads non-red); 3 = illegal transition; 4 = dwell violation; 5 = GR exited without sensor=1 in the previous sample; 6 = RG exited while sensor=1 in the previous sample.
REQ-017 Legal transitions are: stay in the same phase, GR->YR, YR->RR, RR->RG, RG->RY and RY->GR; any other change between consecutive samples is code 3, and any change out of ILL is also code 3.
REQ-018 A dwell counter shall count consecutive samples in the current phase; leaving YR or RY with dwell != YEL_CYC, or leaving RR with dwell != ALLRED_CYC, is code 4.
REQ-019 Remaining in YR or RY beyond YEL_CYC samples, or in RR beyond ALLRED_CYC samples, shall be flagged as code 4 on the first excess sample, once per phase occupancy.
REQ-020 GR and RG have no maximum dwell; the dwell counter shall saturate at its maximum value and never wrap.
REQ-021 When one sample raises several errors, err_code shall latch the highest-priority one and viol_cnt shall increment by exactly 1.
REQ-022 err_code shall latch on the first erroring sample and hold until reset; err shall be 1 whenever err_code != 0.
REQ-023 viol_cnt shall saturate at all-ones.
REQ-024 cycle_done shall pulse for one cycle on a legal RY->GR transition, whether or not err is set.
REQ-025 Transition, dwell and sensor checks shall be skipped on the first sample after reset; code 1 and code 2 checks shall apply on that sample.

Reset
REQ-026 While reset=1 on a clock edge: phase=0 (GR), err=0, err_code=0, viol_cnt=0, cycle_done=0, the dwell counter is cleared, and the first-sample flag is set.
REQ-027 Reset asserted mid-sequence shall discard all history; no violation shall be attributed to the sample taken while reset is high.

Structure
REQ-028 Package traffic_pkg shall hold the colour codes, the phase encoding and the error-code constants; the controller shall share this package.
REQ-029 Combinational decode shall live in sub-module tl_phase_decode ({hwy, cntry} -> phase, illegal, conflict); all remaining logic stays in the top level.

Verification
REQ-030 Legal cycle GR x3 (sensor=1 on the last) -> YR -> RR -> RG x2 (sensor=0 on the last) -> RY -> GR -> err=0, viol_cnt=0, and cycle_done pulses once, one cycle after GR returns.
REQ-031 hwy=10 with cntry=10 for 1 cycle -> err=1, err_code=2, viol_cnt=1 one cycle later.
REQ-032 GR->YR with sensor=0 in the prior sample -> err_code=5; then YR held 2 cycles -> viol_cnt=2 and err_code stays 5.
REQ-033 Jump GR->RG -> err_code=3; hwy=11 thereafter for 300 cycles -> viol_cnt=255 (saturated).
REQ-034 Inject an error, assert reset for 1 cycle mid-RR, then run a legal cycle -> err=0, viol_cnt=0, no violation from the first post-reset sample.
REQ-035 Run with YEL_CYC=2 and a 1-cycle YR -> err_code=4.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared light colour codes, phase encoding and checker error codes.
// Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        CLR_RED     = 2'b00,
        CLR_YELLOW  = 2'b01,
        CLR_GREEN   = 2'b10,
        CLR_ILLEGAL = 2'b11
    } colour_e;

    typedef enum logic [2:0] {
        PH_GR  = 3'd0,
        PH_YR  = 3'd1,
        PH_RR  = 3'd2,
        PH_RG  = 3'd3,
        PH_RY  = 3'd4,
        PH_ILL = 3'd7
    } phase_e;

    localparam logic [2:0] c_ERR_NONE      = 3'd0;
    localparam logic [2:0] c_ERR_ILLEGAL   = 3'd1;
    localparam logic [2:0] c_ERR_CONFLICT  = 3'd2;
    localparam logic [2:0] c_ERR_TRANS     = 3'd3;
    localparam logic [2:0] c_ERR_DWELL     = 3'd4;
    localparam logic [2:0] c_ERR_GR_SENSOR = 3'd5;
    localparam logic [2:0] c_ERR_RG_SENSOR = 3'd6;

    // A phase change is legal only along the fixed GR->YR->RR->RG->RY->GR ring.
    function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph);
        logic ok;
        case (from_ph)
            PH_GR:   ok = (to_ph == PH_YR);
            PH_YR:   ok = (to_ph == PH_RR);
            PH_RR:   ok = (to_ph == PH_RG);
            PH_RG:   ok = (to_ph == PH_RY);
            PH_RY:   ok = (to_ph == PH_GR);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_phase_decode.sv
`default_nettype none
// ============================================================================
// Module   : tl_phase_decode
// Purpose  : Combinational decode of the two light codes into a phase.
// Revision : 1.0  initial release
// ============================================================================
module tl_phase_decode
    import traffic_pkg::*;
(
    input  logic [1:0] hwy_i,
    input  logic [1:0] cntry_i,
    output phase_e     phase_o,
    output logic       illegal_o,
    output logic       conflict_o
);

    always_comb begin
        illegal_o  = (hwy_i == CLR_ILLEGAL) || (cntry_i == CLR_ILLEGAL);
        conflict_o = (hwy_i != CLR_RED) && (cntry_i != CLR_RED);
        case ({hwy_i, cntry_i})
            {CLR_GREEN,  CLR_RED}:    phase_o = PH_GR;
            {CLR_YELLOW, CLR_RED}:    phase_o = PH_YR;
            {CLR_RED,    CLR_RED}:    phase_o = PH_RR;
            {CLR_RED,    CLR_GREEN}:  phase_o = PH_RG;
            {CLR_RED,    CLR_YELLOW}: phase_o = PH_RY;
            default:                  phase_o = PH_ILL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_checker.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_checker
// Purpose  : Monitors a highway/country-road light controller for protocol errors.
// Revision : 1.0  initial release
// ============================================================================
module traffic_light_checker
    import traffic_pkg::*;
#(
    parameter int YEL_CYC    = 1,
    parameter int ALLRED_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       hwy,
    input  logic [1:0]       cntry,
    input  logic             sensor,
    output logic [2:0]       phase,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             cycle_done
);

    // Counter must reach one past the longest timed dwell so overstay stays distinguishable.
    localparam int c_DWELL_LIM = ((YEL_CYC > ALLRED_CYC) ? YEL_CYC : ALLRED_CYC) + 1;
    localparam int c_DW_W      = $clog2(c_DWELL_LIM + 1);
    localparam logic [c_DW_W-1:0] c_YEL    = c_DW_W'(YEL_CYC);
    localparam logic [c_DW_W-1:0] c_ALLRED = c_DW_W'(ALLRED_CYC);

    phase_e            w_cur;
    logic              w_illegal;
    logic              w_conflict;
    logic              w_e_trans;
    logic              w_e_dwell;
    logic              w_e_gr;
    logic              w_e_rg;
    logic [2:0]        w_code;

    phase_e            phase_q;
    logic [c_DW_W-1:0] dwell_q,    dwell_d;
    logic              sens_q;
    logic              first_q;
    logic [2:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  viol_q,     viol_d;
    logic              done_q,     done_d;

    tl_phase_decode u_decode (
        .hwy_i      (hwy),
        .cntry_i    (cntry),
        .phase_o    (w_cur),
        .illegal_o  (w_illegal),
        .conflict_o (w_conflict)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= PH_GR;
            dwell_q    <= '0;
            sens_q     <= 1'b0;
            first_q    <= 1'b1;
            err_code_q <= c_ERR_NONE;
            viol_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            phase_q    <= w_cur;
            dwell_q    <= dwell_d;
            sens_q     <= sensor;
            first_q    <= 1'b0;
            err_code_q <= err_code_d;
            viol_q     <= viol_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        w_e_trans = 1'b0;
        w_e_dwell = 1'b0;
        w_e_gr    = 1'b0;
        w_e_rg    = 1'b0;
        done_d    = 1'b0;
        dwell_d   = c_DW_W'(1);
        if (!first_q) begin
            if (w_cur != phase_q) begin
                w_e_trans = !legal_step(phase_q, w_cur);
                if ((phase_q == PH_YR || phase_q == PH_RY) && dwell_q != c_YEL)
                    w_e_dwell = 1'b1;
                if (phase_q == PH_RR && dwell_q != c_ALLRED)
                    w_e_dwell = 1'b1;
                w_e_gr = (phase_q == PH_GR) && !sens_q;
                w_e_rg = (phase_q == PH_RG) && sens_q;
                done_d = (phase_q == PH_RY) && (w_cur == PH_GR);
            end else begin
                dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + c_DW_W'(1);
                // Overstay fires only on the sample where the count first passes the limit.
                if ((phase_q == PH_YR || phase_q == PH_RY) && dwell_q == c_YEL)
                    w_e_dwell = 1'b1;
                if (phase_q == PH_RR && dwell_q == c_ALLRED)
                    w_e_dwell = 1'b1;
            end
        end

        if (w_illegal)      w_code = c_ERR_ILLEGAL;
        else if (w_conflict) w_code = c_ERR_CONFLICT;
        else if (w_e_trans)  w_code = c_ERR_TRANS;
        else if (w_e_dwell)  w_code = c_ERR_DWELL;
        else if (w_e_gr)     w_code = c_ERR_GR_SENSOR;
        else if (w_e_rg)     w_code = c_ERR_RG_SENSOR;
        else                 w_code = c_ERR_NONE;

        err_code_d = (err_code_q == c_ERR_NONE) ? w_code : err_code_q;
        viol_d     = (w_code != c_ERR_NONE && viol_q != '1) ? viol_q + CNT_W'(1) : viol_q;
    end

    assign phase      = phase_q;
    assign err        = (err_code_q != c_ERR_NONE);
    assign err_code   = err_code_q;
    assign viol_cnt   = viol_q;
    assign cycle_done = done_q;

endmodule
`default_nettype wire
